// File: rtl/fc_event_pkg.sv
// rtl/fc_event_pkg.sv - default constants and round-robin pick function for fc_event_gen
package fc_event_pkg;

  localparam int N_SRC_DEF = 8;
  localparam int CNT_W_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int RR_MAX    = 64;
  localparam int RR_IW     = $clog2(RR_MAX);

  // Returns the first set request at or after (last+1) mod n; returns last when none is set.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int last, input int n);
    logic [RR_IW-1:0] idx;
    rr_pick = last;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = RR_IW'((last + k) % n);
        if (req[idx]) rr_pick = int'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/fc_event_fifo.sv
// rtl/fc_event_fifo.sv - registered power-of-2 FIFO with push/pop/full/empty
module fc_event_fifo
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
)(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign full_o     = (count == CW'(DEPTH));
  assign empty_o    = (count == '0);
  assign wr_en      = push_i && !full_o;
  assign rd_en      = pop_i && !empty_o;
  assign pop_data_o = mem[rd_ptr];

  // Storage is cleared on reset so the data output reads zero while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fc_event_gen.sv
// rtl/fc_event_gen.sv - per-source event counters, round-robin arbiter and ID FIFO
// FC_EVENT_GEN_OVF_STATUS_EN adds sticky per-source overflow flags (ovf_o, ovf_clr_i).
module fc_event_gen
  import fc_event_pkg::*;
#(
  parameter int N_SRC          = N_SRC_DEF,
  parameter int EVENT_ID_WIDTH = 8,
  parameter int ID_BASE        = 0,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int DEPTH          = DEPTH_DEF
)(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_SRC-1:0]          events_i,
  output logic                      event_fifo_valid_o,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
`ifdef FC_EVENT_GEN_OVF_STATUS_EN
  input  logic                      ovf_clr_i,
  output logic [N_SRC-1:0]          ovf_o,
`endif
  input  logic                      event_fifo_fulln_i
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  if ((64'(ID_BASE) + 64'(N_SRC)) > (64'd1 << EVENT_ID_WIDTH) || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || N_SRC < 1 || N_SRC > RR_MAX) begin : g_bad_cfg
    $error("fc_event_gen: illegal parameter combination");
  end

  logic [CNT_W-1:0]          pend [N_SRC];
  logic [N_SRC-1:0]          req;
  logic [N_SRC-1:0]          gnt_vec;
  logic [SW-1:0]             last_grant;
  logic [SW-1:0]             grant_sel;
  int                        grant_pick;
  logic                      grant_vld;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [EVENT_ID_WIDTH-1:0] push_data;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) req[i] = (pend[i] != '0);
    grant_pick = rr_pick(RR_MAX'(req), int'(last_grant), N_SRC);
    grant_sel  = SW'(grant_pick);
    grant_vld  = (|req) && !fifo_full;
    for (int i = 0; i < N_SRC; i++) gnt_vec[i] = grant_vld && (grant_sel == SW'(i));
    push_data  = EVENT_ID_WIDTH'(ID_BASE + grant_pick);
  end

  // Arrival and grant in the same cycle cancel; arrival at saturation is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_SRC; i++) pend[i] <= '0;
      last_grant <= SW'(N_SRC - 1);
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (events_i[i] && !gnt_vec[i]) begin
          if (pend[i] != PEND_MAX) pend[i] <= pend[i] + 1'b1;
        end else if (!events_i[i] && gnt_vec[i]) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
      if (grant_vld) last_grant <= grant_sel;
    end
  end

`ifdef FC_EVENT_GEN_OVF_STATUS_EN
  logic [N_SRC-1:0] drop;

  always_comb begin
    for (int i = 0; i < N_SRC; i++)
      drop[i] = events_i[i] && !gnt_vec[i] && (pend[i] == PEND_MAX);
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_o <= '0;
    else         ovf_o <= (ovf_o & ~{N_SRC{ovf_clr_i}}) | drop;
  end
`endif

  assign event_fifo_valid_o = !fifo_empty;

  fc_event_fifo #(
    .WIDTH (EVENT_ID_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (grant_vld),
    .push_data_i (push_data),
    .pop_i       (event_fifo_valid_o && event_fifo_fulln_i),
    .pop_data_o  (event_fifo_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_fc_event_gen.sv
// tb/tb_fc_event_gen.sv - directed self-checking bench for fc_event_gen
module tb_fc_event_gen;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] events;
  logic       fulln;
  logic       valid;
  logic [7:0] data;
`ifdef FC_EVENT_GEN_OVF_STATUS_EN
  logic       ovf_clr;
  logic [7:0] ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fc_event_gen dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .events_i           (events),
    .event_fifo_valid_o (valid),
    .event_fifo_data_o  (data),
`ifdef FC_EVENT_GEN_OVF_STATUS_EN
    .ovf_clr_i          (ovf_clr),
    .ovf_o              (ovf),
`endif
    .event_fifo_fulln_i (fulln)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    events = '0;
    fulln  = 1'b1;
`ifdef FC_EVENT_GEN_OVF_STATUS_EN
    ovf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    events = '0;
    fulln  = 1'b1;
`ifdef FC_EVENT_GEN_OVF_STATUS_EN
    ovf_clr = 1'b0;
`endif
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
`ifdef FC_EVENT_GEN_OVF_STATUS_EN
    checks++;
    if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h want 00", ovf); end
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_single_pulse;
    do_reset();
    events = 8'h08;
    tick();
    events = '0;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %b want 0", valid); end
    tick();
    checks++;
    if (valid !== 1'b1 || data !== 8'h03) begin
      errors++; $display("FAIL single_t2: got valid=%b data=%h want valid=1 data=03", valid, data);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_t3_valid: got %b want 0", valid); end
  endtask

  task automatic test_all_sources;
    do_reset();
    events = 8'hFF;
    tick();
    events = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (valid !== 1'b1 || data !== 8'(i)) begin
        errors++; $display("FAIL all_src_%0d: got valid=%b data=%h want valid=1 data=%h", i, valid, data, 8'(i));
      end
      tick();
    end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL all_src_end_valid: got %b want 0", valid); end
  endtask

  task automatic test_backpressure;
    logic [7:0] got [$];
    do_reset();
    fulln = 1'b0;
    for (int s = 0; s < 6; s++) begin
      events = 8'(1 << s);
      tick();
    end
    events = '0;
    repeat (4) tick();
    checks++;
    if (valid !== 1'b1 || data !== 8'h00) begin
      errors++; $display("FAIL bp_head: got valid=%b data=%h want valid=1 data=00", valid, data);
    end
    tick();
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL bp_stable: got %h want 00", data); end
    fulln = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (valid) got.push_back(data);
      tick();
    end
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= got.size()) begin
        errors++; $display("FAIL bp_id_%0d: got none want %h", k, 8'(k));
      end else if (got[k] !== 8'(k)) begin
        errors++; $display("FAIL bp_id_%0d: got %h want %h", k, got[k], 8'(k));
      end
    end
  endtask

  task automatic test_saturate;
    int n_two;
    int n_other;
    do_reset();
    fulln  = 1'b0;
    events = 8'h04;
    repeat (8) tick();
    events = '0;
    tick();
`ifdef FC_EVENT_GEN_OVF_STATUS_EN
    checks++;
    if (ovf !== 8'h04) begin errors++; $display("FAIL sat_ovf_set: got %h want 04", ovf); end
`endif
    fulln   = 1'b1;
    n_two   = 0;
    n_other = 0;
    for (int c = 0; c < 30; c++) begin
      if (valid) begin
        if (data === 8'h02) n_two++;
        else n_other++;
      end
      tick();
    end
    checks++;
    if (n_two != 7 || n_other != 0) begin
      errors++; $display("FAIL sat_delivered: got %0d id2 and %0d others want 7 and 0", n_two, n_other);
    end
`ifdef FC_EVENT_GEN_OVF_STATUS_EN
    checks++;
    if (ovf !== 8'h04) begin errors++; $display("FAIL sat_ovf_sticky: got %h want 04", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 8'h00) begin errors++; $display("FAIL sat_ovf_clr: got %h want 00", ovf); end
`endif
  endtask

  task automatic test_round_robin;
    logic [7:0] exp;
    do_reset();
    events = 8'h22;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      exp = (k % 2 == 0) ? 8'h01 : 8'h05;
      checks++;
      if (valid !== 1'b1 || data !== exp) begin
        errors++; $display("FAIL rr_%0d: got valid=%b data=%h want valid=1 data=%h", k, valid, data, exp);
      end
      tick();
    end
    events = '0;
    repeat (10) tick();
  endtask

  task automatic test_mid_reset;
    int stale;
    do_reset();
    fulln  = 1'b0;
    events = 8'h07;
    tick();
    events = '0;
    repeat (3) tick();
    checks++;
    if (valid !== 1'b1 || data !== 8'h00) begin
      errors++; $display("FAIL mr_pre: got valid=%b data=%h want valid=1 data=00", valid, data);
    end
    events = 8'h80;
    tick();
    events = '0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b want 0", valid); end
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL mr_data: got %h want 00", data); end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    fulln  = 1'b1;
    stale  = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mr_stale: got %0d valid cycles want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_all_sources();
    test_backpressure();
    test_saturate();
    test_round_robin();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
